// File: rtl/trace_mem_arbiter_if.sv
// trace_mem_arbiter_if: scan-out, writer and RAM port signals of the trace sample memory arbiter.
interface trace_mem_arbiter_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
);
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic              disp_valid;
   logic [DATA_W-1:0] disp_data;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ack;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   modport slave (
      input  disp_req, disp_addr, wr_req, wr_addr, wr_data, mem_rdata,
      output disp_valid, disp_data, wr_ack, mem_en, mem_we, mem_addr, mem_wdata
   );
   modport master (
      output disp_req, disp_addr, wr_req, wr_addr, wr_data, mem_rdata,
      input  disp_valid, disp_data, wr_ack, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/trace_mem_arbiter.sv
// trace_mem_arbiter: single-port sample RAM shared by scan-out reads (absolute priority, 3-cycle latency) and writer fills.
// Define TRACE_FRAME_LOCK_EN to restrict writer acks to vertical blanking.
module trace_mem_arbiter #(
   parameter int ADDR_W     = 7,
   parameter int DATA_W     = 8,
   parameter int STARVE_MAX = 1023
) (
   input  logic clk,
   input  logic rst,
   input  logic vblank,
   input  logic status_clr,
   output logic trace_done,
   output logic wr_starved,
   trace_mem_arbiter_if.slave bus
);
   localparam logic [15:0] SMAX = 16'(STARVE_MAX);
   typedef enum logic [1:0] {IDLE, RD, WR} state_t;
   state_t      state, state_d;
   logic        wr_allowed;
   logic        rd_d;
   logic [15:0] starve_cnt;
`ifdef TRACE_FRAME_LOCK_EN
   assign wr_allowed = vblank;
`else
   // vblank has no effect here; folded in only so the port is consumed
   assign wr_allowed = 1'b1 | vblank;
`endif
   always_comb begin
      state_d = rst ? IDLE
              : bus.disp_req ? RD
              : (bus.wr_req && wr_allowed) ? WR : IDLE;
      bus.wr_ack = state_d == WR;
   end
   assign bus.mem_en = state != IDLE;
   assign bus.mem_we = state == WR;
   assign trace_done = state == WR && &bus.mem_addr;
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         rd_d          <= 1'b0;
         bus.disp_valid <= 1'b0;
         bus.disp_data <= '0;
         starve_cnt    <= '0;
         wr_starved    <= 1'b0;
      end else begin
         state <= state_d;
         if (state_d == RD)
            bus.mem_addr <= bus.disp_addr;
         else if (state_d == WR) begin
            bus.mem_addr  <= bus.wr_addr;
            bus.mem_wdata <= bus.wr_data;
         end
         // RAM returns read data the cycle after the read is on the port
         rd_d           <= state == RD;
         bus.disp_valid <= rd_d;
         if (rd_d)
            bus.disp_data <= bus.mem_rdata;
         starve_cnt <= (bus.wr_req && !bus.wr_ack)
                     ? ((starve_cnt == SMAX) ? starve_cnt : starve_cnt + 16'd1) : '0;
         wr_starved <= (starve_cnt == SMAX) || (wr_starved && !status_clr);
      end
   end
endmodule

// File: tb/tb_trace_mem_arbiter.sv
// tb_trace_mem_arbiter: directed and randomized checks of trace_mem_arbiter against a queue/array reference model.
module tb_trace_mem_arbiter;
   localparam int SMAX = 1023;
   logic clk, rst, vblank, status_clr, trace_done, wr_starved;
   trace_mem_arbiter_if #(.ADDR_W(7), .DATA_W(8)) bus ();
   trace_mem_arbiter #(.ADDR_W(7), .DATA_W(8), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst), .vblank(vblank), .status_clr(status_clr),
      .trace_done(trace_done), .wr_starved(wr_starved), .bus(bus)
   );
   initial clk = 0;
   always #5 clk = ~clk;
   logic [7:0] ram [128];
   always @(posedge clk)
      if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
         else bus.mem_rdata <= ram[bus.mem_addr];
      end
   int errors = 0, checks = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   logic [7:0] shadow [128];
   int         due_q[$];
   logic [7:0] dat_q[$];
   int         cyc = 0, m_cnt = 0, m_op = 0, trace_cnt = 0, rise_cyc = -1;
   logic [6:0] m_addr = 0;
   logic [7:0] m_wdata = 0;
   logic       m_trace = 0, m_starved = 0, last_ack = 0, prev_starved = 0;
   function automatic logic allowed();
`ifdef TRACE_FRAME_LOCK_EN
      return vblank;
`else
      return 1'b1;
`endif
   endfunction
   task automatic cycle();
      logic exp_ack;
      @(negedge clk);
      exp_ack = !rst && !bus.disp_req && bus.wr_req && allowed();
      chk("wr_ack", bus.wr_ack, exp_ack);
      chk("mem_en", bus.mem_en, m_op != 0);
      chk("mem_we", bus.mem_we, m_op == 2);
      if (m_op != 0) chk("mem_addr", bus.mem_addr, m_addr);
      if (m_op == 2) chk("mem_wdata", bus.mem_wdata, m_wdata);
      if (due_q.size() != 0 && due_q[0] == cyc) begin
         chk("disp_valid", bus.disp_valid, 1);
         chk("disp_data", bus.disp_data, dat_q[0]);
         void'(due_q.pop_front());
         void'(dat_q.pop_front());
      end else
         chk("disp_valid", bus.disp_valid, 0);
      chk("trace_done", trace_done, m_trace);
      chk("wr_starved", wr_starved, m_starved);
      if (trace_done) trace_cnt++;
      if (wr_starved && !prev_starved) rise_cyc = cyc;
      prev_starved = wr_starved;
      if (rst) begin
         due_q.delete();
         dat_q.delete();
         m_cnt = 0; m_starved = 0; m_trace = 0; m_op = 0;
      end else begin
         if (bus.disp_req) begin
            due_q.push_back(cyc + 3);
            dat_q.push_back(shadow[bus.disp_addr]);
            m_op = 1; m_addr = bus.disp_addr;
         end else if (exp_ack) begin
            shadow[bus.wr_addr] = bus.wr_data;
            m_op = 2; m_addr = bus.wr_addr; m_wdata = bus.wr_data;
         end else
            m_op = 0;
         m_trace = exp_ack && bus.wr_addr == 7'd127;
         m_starved = (m_cnt == SMAX) || (m_starved && !status_clr);
         m_cnt = (bus.wr_req && !exp_ack) ? ((m_cnt < SMAX) ? m_cnt + 1 : SMAX) : 0;
      end
      last_ack = exp_ack;
      cyc++;
      @(posedge clk);
      #1;
   endtask
   initial begin
      logic [7:0] v;
      int t0;
      rst = 1; vblank = 0; status_clr = 0;
      bus.disp_req = 0; bus.disp_addr = 0;
      bus.wr_req = 1; bus.wr_addr = 7'd9; bus.wr_data = 8'h99;
      for (int i = 0; i < 128; i++) begin
         v = 8'($urandom);
         ram[i] <= v;
         shadow[i] = v;
      end
      @(posedge clk);
      #1;
      cycle();
      cycle();
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_disp_valid", bus.disp_valid, 0);
      chk("rst_disp_data", bus.disp_data, 0);
      chk("rst_trace_done", trace_done, 0);
      chk("rst_wr_starved", wr_starved, 0);
`ifdef TRACE_FRAME_LOCK_EN
      vblank = 1;
`endif
      rst = 0;
      cycle();
      bus.wr_req = 0;
      cycle();
      // single read of a preloaded sample
      ram[5] <= 8'hA5;
      shadow[5] = 8'hA5;
      cycle();
      bus.disp_req = 1; bus.disp_addr = 7'd5;
      cycle();
      bus.disp_req = 0;
      repeat (4) cycle();
      // write blocked by continuous display reads, then served
      bus.wr_req = 1; bus.wr_addr = 7'd3; bus.wr_data = 8'h3C;
      bus.disp_req = 1;
      for (int i = 0; i < 10; i++) begin
         bus.disp_addr = 7'($urandom);
         cycle();
      end
      bus.disp_req = 0;
      cycle();
      bus.wr_req = 0;
      bus.disp_req = 1; bus.disp_addr = 7'd3;
      cycle();
      bus.disp_req = 0;
      repeat (4) cycle();
      // full trace stream
      trace_cnt = 0;
      for (int i = 0; i < 128; i++) begin
         bus.wr_req = 1; bus.wr_addr = 7'(i); bus.wr_data = 8'($urandom);
         cycle();
      end
      bus.wr_req = 0;
      repeat (3) cycle();
      chk("trace_once", trace_cnt, 1);
      // starvation
      bus.wr_req = 1; bus.wr_addr = 7'd20; bus.wr_data = 8'h20;
      bus.disp_req = 1;
      t0 = cyc; rise_cyc = -1;
      for (int i = 0; i < 1030; i++) begin
         bus.disp_addr = 7'($urandom);
         cycle();
      end
      chk("starve_rise", rise_cyc - t0, 1024);
      bus.disp_req = 0;
      cycle();
      bus.wr_req = 0;
      repeat (3) cycle();
      chk("starve_hold", wr_starved, 1);
      status_clr = 1;
      cycle();
      status_clr = 0;
      cycle();
      chk("starve_clr", wr_starved, 0);
      // reset with a read in flight
      bus.disp_req = 1; bus.disp_addr = 7'd40;
      cycle();
      bus.disp_req = 0; rst = 1;
      cycle();
      rst = 0;
      repeat (5) cycle();
      // frame lock gating (vblank ignored when the feature is off)
      vblank = 0; bus.wr_req = 1; bus.wr_addr = 7'd50; bus.wr_data = 8'h50;
      repeat (3) cycle();
      vblank = 1;
      cycle();
      bus.wr_req = 0;
      cycle();
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if (!bus.wr_req || last_ack) begin
            bus.wr_req = $urandom_range(0, 2) != 0;
            bus.wr_addr = 7'($urandom);
            bus.wr_data = 8'($urandom);
         end
         bus.disp_req = $urandom_range(0, 1) == 1;
         bus.disp_addr = 7'($urandom);
         status_clr = $urandom_range(0, 50) == 0;
         vblank = $urandom_range(0, 3) != 0;
         rst = $urandom_range(0, 200) == 0;
         cycle();
      end
      rst = 0; bus.disp_req = 0; bus.wr_req = 0;
      repeat (4) cycle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
